// File: rtl/ipg_rx.sv
// ipg_rx: strips IPG request/memory-reply blocks from the RX gap into two FWFT chunk FIFOs
// and forwards the network stream with idles in their place. Define IPG_RX_STATS_EN for counters.
module ipg_rx #(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         MSG_MAX_BLKS = 4,
    parameter logic [7:0] IPG_REQ_BT   = 8'h3c,
    parameter logic [7:0] IPG_MEM_BT   = 8'h5a
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] encoded_rx_data,
    input  logic [1:0]  encoded_rx_hdr,
    input  logic        rx_valid,
    output logic [63:0] proced_encoded_rx_data,
    output logic [1:0]  proced_encoded_rx_hdr,
    output logic        proced_rx_valid,
    output logic [63:0] req_chunk,
    output logic        req_last,
    output logic        req_abort,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] mem_chunk,
    output logic        mem_last,
    output logic        mem_abort,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        proto_err,
    output logic [15:0] req_msg_cnt,
    output logic [15:0] mem_msg_cnt,
    output logic [15:0] drop_cnt
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam int          BW       = $clog2(MSG_MAX_BLKS + 1);
    localparam logic [63:0] IDLE_BLK = 64'h1e;
    localparam logic [1:0]  HDR_CTRL = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_IN_REQ, S_IN_MEM, S_DROP} state_t;

    typedef struct packed {
        logic        abort;
        logic        last;
        logic [63:0] chunk;
    } entry_t;

    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_blk_cnt, w_cnt_nxt;
    logic          r_drop_typ, w_drop_typ_nxt;
    logic          r_in_frame;
    logic [63:0]   r_out_data;
    logic [1:0]    r_out_hdr;
    logic          r_out_valid;
    logic          r_proto_err;

    logic [7:0]    w_bt;
    logic          w_ctrl, w_bad_hdr, w_is_req, w_is_mem, w_is_ipg;
    logic          w_typ, w_last, w_start, w_term;
    logic          w_acc_ipg, w_frame_start, w_open_typ, w_reproc;
    logic [1:0]    w_push, w_pop, w_valid, w_ready, w_room, w_done;
    logic          w_drop_inc;
    entry_t [1:0]  w_push_ent, w_head;

    // Block classification; index 0 is the request FIFO, index 1 the memory-reply FIFO.
    assign w_bt          = encoded_rx_data[7:0];
    assign w_ctrl        = (encoded_rx_hdr == HDR_CTRL);
    assign w_bad_hdr     = (encoded_rx_hdr == 2'b00) || (encoded_rx_hdr == 2'b11);
    assign w_is_req      = w_ctrl && (w_bt == IPG_REQ_BT);
    assign w_is_mem      = w_ctrl && (w_bt == IPG_MEM_BT);
    assign w_is_ipg      = w_is_req || w_is_mem;
    assign w_typ         = w_is_mem;
    assign w_last        = encoded_rx_data[8];
    assign w_start       = w_ctrl && (w_bt inside {8'h78, 8'h33, 8'h66});
    assign w_term        = w_ctrl && (w_bt inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff});
    assign w_acc_ipg     = rx_valid && w_is_ipg && !r_in_frame;
    assign w_frame_start = rx_valid && w_start;
    assign w_open_typ    = (r_state == S_IN_MEM);
    assign w_ready       = {mem_ready, req_ready};
    assign w_pop         = w_valid & w_ready;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        entry_t        r_store [FIFO_DEPTH];
        logic [AW-1:0] r_wr_ptr, r_rd_ptr;
        logic [CW-1:0] r_count;

        // NOTE: the storage array is deliberately not reset; r_count alone decides what is visible.
        always_ff @(posedge clk) begin
            if (w_push[g]) r_store[r_wr_ptr] <= w_push_ent[g];
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[g]) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop[g])  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push[g]) - CW'(w_pop[g]);
            end
        end

        assign w_head[g]  = r_store[r_rd_ptr];
        assign w_valid[g] = (r_count != '0);
        assign w_room[g]  = (CW'(FIFO_DEPTH) - r_count) >= CW'(MSG_MAX_BLKS + 1);
    end

    always_comb begin
        // NOTE: every comb output is defaulted first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_blk_cnt;
        w_drop_typ_nxt = r_drop_typ;
        w_push         = '0;
        w_push_ent     = '0;
        w_done         = '0;
        w_drop_inc     = 1'b0;
        w_reproc       = 1'b0;
        case (r_state)
            S_IDLE: w_reproc = w_acc_ipg;
            S_IN_REQ, S_IN_MEM: begin
                if (w_acc_ipg && (w_typ == w_open_typ)) begin
                    w_push[w_typ]     = 1'b1;
                    w_push_ent[w_typ] = '{abort: 1'b0, last: w_last, chunk: encoded_rx_data};
                    w_cnt_nxt         = r_blk_cnt + BW'(1);
                    if (w_last) begin
                        w_state_nxt   = S_IDLE;
                        w_done[w_typ] = 1'b1;
                    end else if (w_cnt_nxt == BW'(MSG_MAX_BLKS)) begin
                        w_push_ent[w_typ].last = 1'b1;
                        w_state_nxt    = S_DROP;
                        w_drop_typ_nxt = w_typ;
                        w_drop_inc     = 1'b1;
                    end
                end else if (w_acc_ipg || w_frame_start) begin
                    // Close the open message with an abort marker; its slot was reserved at start.
                    w_push[w_open_typ]     = 1'b1;
                    w_push_ent[w_open_typ] = '{abort: 1'b1, last: 1'b1, chunk: 64'h0};
                    w_state_nxt            = S_IDLE;
                    w_reproc               = w_acc_ipg;
                end
            end
            S_DROP: begin
                if (w_acc_ipg && (w_typ == r_drop_typ)) begin
                    if (w_last) w_state_nxt = S_IDLE;
                end else if (w_acc_ipg || w_frame_start) begin
                    w_state_nxt = S_IDLE;
                    w_reproc    = w_acc_ipg;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_reproc) begin
            if (w_room[w_typ]) begin
                w_push[w_typ]     = 1'b1;
                w_push_ent[w_typ] = '{abort: 1'b0, last: w_last, chunk: encoded_rx_data};
                w_cnt_nxt         = BW'(1);
                if (w_last) begin
                    w_state_nxt   = S_IDLE;
                    w_done[w_typ] = 1'b1;
                end else if (MSG_MAX_BLKS == 1) begin
                    w_push_ent[w_typ].last = 1'b1;
                    w_state_nxt    = S_DROP;
                    w_drop_typ_nxt = w_typ;
                    w_drop_inc     = 1'b1;
                end else begin
                    w_state_nxt = w_typ ? S_IN_MEM : S_IN_REQ;
                end
            end else begin
                w_drop_inc     = 1'b1;
                w_drop_typ_nxt = w_typ;
                w_state_nxt    = w_last ? S_IDLE : S_DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_blk_cnt   <= '0;
            r_drop_typ  <= 1'b0;
            r_in_frame  <= 1'b0;
            r_out_data  <= IDLE_BLK;
            r_out_hdr   <= HDR_CTRL;
            r_out_valid <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk_cnt   <= w_cnt_nxt;
            r_drop_typ  <= w_drop_typ_nxt;
            r_out_valid <= rx_valid;
            r_proto_err <= rx_valid && (w_bad_hdr || (w_is_ipg && r_in_frame));
            if (rx_valid) begin
                r_out_data <= w_acc_ipg ? IDLE_BLK : encoded_rx_data;
                r_out_hdr  <= w_acc_ipg ? HDR_CTRL : encoded_rx_hdr;
                if (!w_is_ipg) begin
                    if (w_start)     r_in_frame <= 1'b1;
                    else if (w_term) r_in_frame <= 1'b0;
                end
            end
        end
    end

    assign proced_encoded_rx_data = r_out_data;
    assign proced_encoded_rx_hdr  = r_out_hdr;
    assign proced_rx_valid        = r_out_valid;
    assign proto_err              = r_proto_err;
    assign req_chunk = w_head[0].chunk;
    assign req_last  = w_head[0].last;
    assign req_abort = w_head[0].abort;
    assign req_valid = w_valid[0];
    assign mem_chunk = w_head[1].chunk;
    assign mem_last  = w_head[1].last;
    assign mem_abort = w_head[1].abort;
    assign mem_valid = w_valid[1];

`ifdef IPG_RX_STATS_EN
    logic [15:0] r_req_msg_cnt, r_mem_msg_cnt, r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req_msg_cnt <= '0;
            r_mem_msg_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_done[0] && (r_req_msg_cnt != 16'hffff)) r_req_msg_cnt <= r_req_msg_cnt + 16'd1;
            if (w_done[1] && (r_mem_msg_cnt != 16'hffff)) r_mem_msg_cnt <= r_mem_msg_cnt + 16'd1;
            if (w_drop_inc && (r_drop_cnt != 16'hffff))   r_drop_cnt    <= r_drop_cnt + 16'd1;
        end
    end

    assign req_msg_cnt = r_req_msg_cnt;
    assign mem_msg_cnt = r_mem_msg_cnt;
    assign drop_cnt    = r_drop_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = &{1'b0, w_done, w_drop_inc};
    assign req_msg_cnt    = '0;
    assign mem_msg_cnt    = '0;
    assign drop_cnt       = '0;
`endif

endmodule

// File: tb/tb_ipg_rx.sv
// Scoreboard bench for ipg_rx: stimulus pushes expected stream/chunk values, a negedge monitor pops and compares.
module tb_ipg_rx;

    localparam logic [7:0] REQ_BT = 8'h3c;
    localparam logic [7:0] MEM_BT = 8'h5a;
`ifdef IPG_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic        rx_valid;
    logic [63:0] proced_data;
    logic [1:0]  proced_hdr;
    logic        proced_valid;
    logic [63:0] req_chunk, mem_chunk;
    logic        req_last, req_abort, req_valid, req_ready;
    logic        mem_last, mem_abort, mem_valid, mem_ready;
    logic        proto_err;
    logic [15:0] req_msg_cnt, mem_msg_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [66:0] proc_q[$];
    logic [66:0] req_q[$];
    logic [66:0] mem_q[$];

    ipg_rx dut (
        .clk(clk), .reset(reset),
        .encoded_rx_data(rx_data), .encoded_rx_hdr(rx_hdr), .rx_valid(rx_valid),
        .proced_encoded_rx_data(proced_data), .proced_encoded_rx_hdr(proced_hdr),
        .proced_rx_valid(proced_valid),
        .req_chunk(req_chunk), .req_last(req_last), .req_abort(req_abort),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_chunk(mem_chunk), .mem_last(mem_last), .mem_abort(mem_abort),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .proto_err(proto_err),
        .req_msg_cnt(req_msg_cnt), .mem_msg_cnt(mem_msg_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [66:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, expected no output", name, act);
    endtask

    // Monitor: compare every presented stream block and every popped FIFO head.
    always @(negedge clk) begin
        if (proced_valid) begin
            if (proc_q.size() == 0) unexpected("proced_extra", {proto_err, proced_hdr, proced_data});
            else check("proced", {proto_err, proced_hdr, proced_data}, proc_q.pop_front());
        end
        if (req_valid && req_ready) begin
            if (req_q.size() == 0) unexpected("req_extra", {1'b0, req_abort, req_last, req_chunk});
            else check("req_pop", {1'b0, req_abort, req_last, req_chunk}, req_q.pop_front());
        end
        if (mem_valid && mem_ready) begin
            if (mem_q.size() == 0) unexpected("mem_extra", {1'b0, mem_abort, mem_last, mem_chunk});
            else check("mem_pop", {1'b0, mem_abort, mem_last, mem_chunk}, mem_q.pop_front());
        end
    end

    function automatic logic [63:0] ipg(input logic [7:0] bt, input logic last, input logic [54:0] pay);
        return {pay, last, bt};
    endfunction

    task automatic send(input logic [1:0] h, input logic [63:0] d,
                        input logic [1:0] eh, input logic [63:0] ed, input logic ep);
        rx_hdr   = h;
        rx_data  = d;
        rx_valid = 1'b1;
        proc_q.push_back({ep, eh, ed});
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [63:0] d);
        send(2'b01, d, 2'b01, 64'h1e, 1'b0);
    endtask

    task automatic bubble(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        reset = 1'b0;  req_ready = 1'b1;  mem_ready = 1'b1;
        rx_valid = 1'b1;  rx_hdr = 2'b11;  rx_data = 64'hdead_beef_0000_013c;

        // Reset state, with garbage input held valid.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 67'(proced_valid), 67'(0));
        check("rst_hdr", 67'(proced_hdr), 67'(2'b01));
        check("rst_data", 67'(proced_data), 67'h1e);
        check("rst_perr", 67'(proto_err), 67'(0));
        check("rst_chunk_valid", {65'(0), mem_valid, req_valid}, 67'(0));
        check("rst_counters", {19'(0), req_msg_cnt, mem_msg_cnt, drop_cnt}, 67'(0));
        rx_valid = 1'b0;
        reset = 1'b1;
        bubble(2);

        // Idle blocks pass through unchanged.
        for (int i = 0; i < 8; i++) send(2'b01, 64'h1e, 2'b01, 64'h1e, 1'b0);
        bubble(2);
        check("idle_no_chunks", {65'(0), mem_valid, req_valid}, 67'(0));

        // Three-block request message.
        for (int b = 0; b < 3; b++) begin
            d = ipg(REQ_BT, b == 2, 55'(16'h1110 + b));
            req_q.push_back({2'b00, b == 2, d});
            send_gap(d);
        end
        bubble(3);
        check("req_msg_cnt_1", 67'(req_msg_cnt), STATS ? 67'(1) : 67'(0));

        // Fill mem FIFO to 12, then a message that finds only 4 free slots.
        mem_ready = 1'b0;
        for (int m = 0; m < 3; m++) begin
            for (int b = 0; b < 4; b++) begin
                d = ipg(MEM_BT, b == 3, 55'(16'h2000 + m * 4 + b));
                mem_q.push_back({2'b00, b == 3, d});
                send_gap(d);
            end
        end
        send_gap(ipg(MEM_BT, 1'b0, 55'h3001));
        send_gap(ipg(MEM_BT, 1'b1, 55'h3002));
        bubble(1);
        check("drop_cnt_1", 67'(drop_cnt), STATS ? 67'(1) : 67'(0));
        check("mem_msg_cnt_3", 67'(mem_msg_cnt), STATS ? 67'(3) : 67'(0));
        mem_ready = 1'b1;
        bubble(16);
        check("mem_drained", {66'(mem_q.size()), mem_valid}, 67'(0));

        // IPG block inside a frame, then a bad sync header outside it.
        send(2'b01, 64'h1122_3344_5566_7778, 2'b01, 64'h1122_3344_5566_7778, 1'b0);
        send(2'b10, 64'h0123_4567_89ab_cdef, 2'b10, 64'h0123_4567_89ab_cdef, 1'b0);
        d = ipg(REQ_BT, 1'b1, 55'h4444);
        send(2'b01, d, 2'b01, d, 1'b1);
        send(2'b01, 64'h0000_0000_0000_0087, 2'b01, 64'h0000_0000_0000_0087, 1'b0);
        bubble(1);
        send(2'b11, 64'h5555_aaaa_5555_aaaa, 2'b11, 64'h5555_aaaa_5555_aaaa, 1'b1);
        bubble(2);
        check("inframe_no_req", 67'(req_valid), 67'(0));

        // Open request interrupted by a memory block: abort marker closes it.
        d = ipg(REQ_BT, 1'b0, 55'h5001);
        req_q.push_back({3'b000, d});
        req_q.push_back({3'b011, 64'h0});
        send_gap(d);
        d = ipg(MEM_BT, 1'b1, 55'h5002);
        mem_q.push_back({3'b001, d});
        send_gap(d);
        bubble(3);
        check("abort_mem_cnt", 67'(mem_msg_cnt), STATS ? 67'(4) : 67'(0));

        // Five request blocks without LAST: truncated at four, fifth discarded.
        for (int b = 0; b < 5; b++) begin
            d = ipg(REQ_BT, 1'b0, 55'(16'h6000 + b));
            if (b < 4) req_q.push_back({2'b00, b == 3, d});
            send_gap(d);
        end
        send_gap(ipg(REQ_BT, 1'b1, 55'h6005));
        bubble(3);
        check("trunc_drop_cnt", 67'(drop_cnt), STATS ? 67'(2) : 67'(0));
        check("trunc_req_cnt", 67'(req_msg_cnt), STATS ? 67'(1) : 67'(0));

        // Reset in the middle of a message.
        req_ready = 1'b0;
        send_gap(ipg(REQ_BT, 1'b0, 55'h7001));
        send_gap(ipg(REQ_BT, 1'b0, 55'h7002));
        reset = 1'b0;
        bubble(2);
        check("midrst_req_valid", 67'(req_valid), 67'(0));
        check("midrst_counters", {19'(0), req_msg_cnt, mem_msg_cnt, drop_cnt}, 67'(0));
        check("midrst_out", {proto_err, proced_valid, proced_hdr, proced_data}, {3'b001, 64'h1e});
        reset = 1'b1;
        req_ready = 1'b1;
        d = ipg(REQ_BT, 1'b1, 55'h7003);
        req_q.push_back({3'b001, d});
        send_gap(d);
        bubble(3);
        check("postrst_req_cnt", 67'(req_msg_cnt), STATS ? 67'(1) : 67'(0));

        for (int i = 0; i < 50 && (proc_q.size() + req_q.size() + mem_q.size()) > 0; i++) @(posedge clk);
        #1;
        check("proc_q_left", 67'(proc_q.size()), 67'(0));
        check("req_q_left", 67'(req_q.size()), 67'(0));
        check("mem_q_left", 67'(mem_q.size()), 67'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
